// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT frame controller.
//   - fft_state_t : frame sequencer state encoding
//   - LOG2_N_DEF  : default log2 of FFT length (N = 256)
//   - LOG2_N_MAX  : widest supported log2 length
//   - bitrev()    : reverse the low 'w' bits of a value. The twiddle ROM
//                   generator uses this function as well.
package fft_pkg;

  localparam int LOG2_N_DEF = 8;
  localparam int LOG2_N_MAX = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_OUTPUT  = 3'd4
  } fft_state_t;

  // Reverse all LOG2_N_MAX bits, then shift right so that only the low 'w'
  // bits of the input end up reversed into the low 'w' bits of the result.
  function automatic logic [LOG2_N_MAX-1:0] bitrev(input logic [LOG2_N_MAX-1:0] v,
                                                   input int unsigned w);
    logic [LOG2_N_MAX-1:0] full;
    full = '0;
    for (int j = 0; j < LOG2_N_MAX; j++) begin
      full[j] = v[LOG2_N_MAX-1-j];
    end
    return full >> (LOG2_N_MAX - w);
  endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: bundles the sequencer's handshake and RAM/engine signals.
//   master : the sequencer side (drives strobes, addresses and status)
//   slave  : the environment side (deserialiser, engine, serialiser, RAM)
interface fft_sequencer_if import fft_pkg::*; #(
  parameter int LOG2_N = LOG2_N_DEF
) ();

  logic              arm;
  logic              sample_valid;
  logic              cap_we;
  logic [LOG2_N-1:0] cap_addr;
  logic              bfly_valid;
  logic              bfly_ready;
  logic              bfly_idle;
  logic [LOG2_N-1:0] bfly_addr_a;
  logic [LOG2_N-1:0] bfly_addr_b;
  logic [LOG2_N-2:0] bfly_tw;
  logic              out_ready;
  logic              rd_en;
  logic [LOG2_N-1:0] rd_addr;
  logic              out_valid;
  logic              out_sync;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  modport master (
    input  arm, sample_valid, bfly_ready, bfly_idle, out_ready,
    output cap_we, cap_addr, bfly_valid, bfly_addr_a, bfly_addr_b, bfly_tw,
           rd_en, rd_addr, out_valid, out_sync, busy, frame_done, overrun
  );

  modport slave (
    output arm, sample_valid, bfly_ready, bfly_idle, out_ready,
    input  cap_we, cap_addr, bfly_valid, bfly_addr_a, bfly_addr_b, bfly_tw,
           rd_en, rd_addr, out_valid, out_sync, busy, frame_done, overrun
  );

endinterface

// File: rtl/fft_bfly_addr_gen.sv
// fft_bfly_addr_gen: combinational butterfly address generator.
//   stage  : butterfly stage s (0..LOG2_N-1)
//   k      : butterfly index within the stage (0..N/2-1)
//   addr_a : upper operand address  = (k>>s)*2^(s+1) + (k mod 2^s)
//   addr_b : lower operand address  = addr_a + 2^s
//   tw     : twiddle ROM index      = (k mod 2^s) << (LOG2_N-1-s)
module fft_bfly_addr_gen import fft_pkg::*; #(
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic [3:0]        stage,
  input  logic [LOG2_N-2:0] k,
  output logic [LOG2_N-1:0] addr_a,
  output logic [LOG2_N-1:0] addr_b,
  output logic [LOG2_N-2:0] tw
);

  logic [LOG2_N-1:0] k_ext_s;
  logic [LOG2_N-1:0] half_s;
  logic [LOG2_N-1:0] pos_s;
  logic [LOG2_N-1:0] base_s;
  logic [LOG2_N-1:0] tw_full_s;
  logic [3:0]        tw_sh_s;

  // Address terms occupy disjoint bit ranges, so OR replaces the additions
  // and nothing can overflow: base has zeros in bits [s:0], pos < 2^s.
  always_comb begin
    k_ext_s   = {1'b0, k};
    half_s    = LOG2_N'(1'b1) << stage;
    pos_s     = k_ext_s & (half_s - LOG2_N'(1'b1));
    base_s    = (k_ext_s >> stage) << (stage + 4'd1);
    tw_sh_s   = 4'(LOG2_N - 1) - stage;
    tw_full_s = pos_s << tw_sh_s;
    addr_a    = base_s | pos_s;
    addr_b    = base_s | pos_s | half_s;
    tw        = tw_full_s[LOG2_N-2:0];
  end

endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: frame-level controller for the FFT datapath.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   bus  : master side of fft_sequencer_if
//          capture : arm, sample_valid -> cap_we, cap_addr (bit-reversed)
//          compute : bfly_valid/bfly_ready handshake, bfly_idle barrier,
//                    bfly_addr_a/b, bfly_tw
//          output  : out_ready -> rd_en, rd_addr; out_valid, out_sync
//          status  : busy, frame_done, overrun
module fft_sequencer import fft_pkg::*; #(
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  fft_sequencer_if.master bus
);

  fft_state_t        state_r;
  logic [LOG2_N-1:0] count_r;
  logic [3:0]        stage_r;
  logic [LOG2_N-2:0] k_r;
  logic [LOG2_N-1:0] idx_r;
  logic              out_valid_r;
  logic              out_sync_r;
  logic              frame_done_r;
  logic              overrun_r;

  logic                  cap_we_s;
  logic                  rd_en_s;
  logic                  compute_s;
  logic [LOG2_N_MAX-1:0] rev_s;
  logic [LOG2_N-1:0]     addr_a_s;
  logic [LOG2_N-1:0]     addr_b_s;
  logic [LOG2_N-2:0]     tw_s;

  fft_bfly_addr_gen #(.LOG2_N(LOG2_N)) u_addr_gen (
    .stage  (stage_r),
    .k      (k_r),
    .addr_a (addr_a_s),
    .addr_b (addr_b_s),
    .tw     (tw_s)
  );

  // Zero-latency strobes and state decodes of the registered FSM.
  always_comb begin
    cap_we_s  = (state_r == S_CAPTURE) && bus.sample_valid;
    rd_en_s   = (state_r == S_OUTPUT) && bus.out_ready;
    compute_s = (state_r == S_COMPUTE);
    rev_s     = bitrev(LOG2_N_MAX'(count_r), LOG2_N);
  end

  // Request fields depend only on registered stage/k, so they stay stable
  // through bfly_ready stalls; they read zero outside COMPUTE.
  assign bus.cap_we      = cap_we_s;
  assign bus.cap_addr    = (state_r == S_CAPTURE) ? rev_s[LOG2_N-1:0] : '0;
  assign bus.bfly_valid  = compute_s;
  assign bus.bfly_addr_a = compute_s ? addr_a_s : '0;
  assign bus.bfly_addr_b = compute_s ? addr_b_s : '0;
  assign bus.bfly_tw     = compute_s ? tw_s : '0;
  assign bus.rd_en       = rd_en_s;
  assign bus.rd_addr     = (state_r == S_OUTPUT) ? idx_r : '0;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_sync    = out_sync_r;
  assign bus.busy        = (state_r != S_IDLE);
  assign bus.frame_done  = frame_done_r;
  assign bus.overrun     = overrun_r;

  // Frame FSM, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= S_IDLE;
      count_r      <= '0;
      stage_r      <= 4'd0;
      k_r          <= '0;
      idx_r        <= '0;
      out_valid_r  <= 1'b0;
      out_sync_r   <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      out_valid_r  <= rd_en_s;
      out_sync_r   <= rd_en_s && (idx_r == '0);
      frame_done_r <= rd_en_s && (idx_r == {LOG2_N{1'b1}});

      // arm wins over a coincident sample: that sample is neither
      // captured nor flagged.
      if ((state_r == S_IDLE) && bus.arm) begin
        overrun_r <= 1'b0;
      end else if (bus.sample_valid && (state_r != S_CAPTURE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      case (state_r)
        S_IDLE: begin
          if (bus.arm) begin
            state_r <= S_CAPTURE;
            count_r <= '0;
          end
        end
        S_CAPTURE: begin
          if (bus.sample_valid) begin
            if (count_r == {LOG2_N{1'b1}}) begin
              state_r <= S_COMPUTE;
              count_r <= '0;
              stage_r <= 4'd0;
              k_r     <= '0;
            end else begin
              count_r <= count_r + LOG2_N'(1'b1);
            end
          end
        end
        S_COMPUTE: begin
          if (bus.bfly_ready) begin
            if (k_r == {(LOG2_N-1){1'b1}}) begin
              state_r <= S_DRAIN;
              k_r     <= '0;
            end else begin
              k_r <= k_r + (LOG2_N-1)'(1'b1);
            end
          end
        end
        S_DRAIN: begin
          // Stage barrier: the next stage reads what this one writes back.
          if (bus.bfly_idle) begin
            k_r <= '0;
            if (stage_r == 4'(LOG2_N - 1)) begin
              state_r <= S_OUTPUT;
              stage_r <= 4'd0;
              idx_r   <= '0;
            end else begin
              state_r <= S_COMPUTE;
              stage_r <= stage_r + 4'd1;
            end
          end
        end
        S_OUTPUT: begin
          if (rd_en_s) begin
            if (idx_r == {LOG2_N{1'b1}}) begin
              state_r <= S_IDLE;
              idx_r   <= '0;
            end else begin
              idx_r <= idx_r + LOG2_N'(1'b1);
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed, table-driven bench for fft_sequencer at N = 8.
module tb_fft_sequencer;
  import fft_pkg::*;

  localparam int LN = 3;

  typedef struct {
    logic       sv;
    logic       exp_we;
    logic [2:0] exp_addr;
  } cap_vec_t;

  typedef struct {
    int         stall;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
  } bfly_vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  cap_vec_t  cap_tab [10];
  bfly_vec_t bf_tab  [12];

  always #5 clk = ~clk;

  fft_sequencer_if #(.LOG2_N(LN)) bus ();

  fft_sequencer #(.LOG2_N(LN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Handshake counter over the whole run.
  always @(posedge clk) begin
    if (bus.bfly_valid && bus.bfly_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.cap_we, bus.cap_addr, bus.bfly_valid, bus.bfly_addr_a, bus.bfly_addr_b,
                bus.bfly_tw, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_sync,
                bus.busy, bus.frame_done, bus.overrun});
  endfunction

  function automatic logic [31:0] bfly_fields();
    return 32'({bus.bfly_valid, bus.bfly_addr_a, bus.bfly_addr_b, bus.bfly_tw});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    int         n_rd;
    int         n_sync;
    int         exp_idx;
    logic       prev_rd;
    logic [2:0] prev_addr;
    logic       rdy;
    logic       done_seen;

    cap_tab[0] = '{1'b1, 1'b1, 3'd0};
    cap_tab[1] = '{1'b1, 1'b1, 3'd4};
    cap_tab[2] = '{1'b0, 1'b0, 3'd0};
    cap_tab[3] = '{1'b1, 1'b1, 3'd2};
    cap_tab[4] = '{1'b1, 1'b1, 3'd6};
    cap_tab[5] = '{1'b1, 1'b1, 3'd1};
    cap_tab[6] = '{1'b0, 1'b0, 3'd0};
    cap_tab[7] = '{1'b1, 1'b1, 3'd5};
    cap_tab[8] = '{1'b1, 1'b1, 3'd3};
    cap_tab[9] = '{1'b1, 1'b1, 3'd7};

    bf_tab[0]  = '{0, 3'd0, 3'd1, 2'd0};
    bf_tab[1]  = '{2, 3'd2, 3'd3, 2'd0};
    bf_tab[2]  = '{0, 3'd4, 3'd5, 2'd0};
    bf_tab[3]  = '{1, 3'd6, 3'd7, 2'd0};
    bf_tab[4]  = '{1, 3'd0, 3'd2, 2'd0};
    bf_tab[5]  = '{0, 3'd1, 3'd3, 2'd2};
    bf_tab[6]  = '{3, 3'd4, 3'd6, 2'd0};
    bf_tab[7]  = '{0, 3'd5, 3'd7, 2'd2};
    bf_tab[8]  = '{0, 3'd0, 3'd4, 2'd0};
    bf_tab[9]  = '{1, 3'd1, 3'd5, 2'd1};
    bf_tab[10] = '{0, 3'd2, 3'd6, 2'd2};
    bf_tab[11] = '{2, 3'd3, 3'd7, 2'd3};

    rstn             = 1'b0;
    bus.arm          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.bfly_ready   = 1'b0;
    bus.bfly_idle    = 1'b1;
    bus.out_ready    = 1'b0;

    // Reset state.
    repeat (3) cyc();
    chk("in_reset_outs", all_outs(), 32'd0);
    rstn = 1'b1;
    cyc();
    chk("post_reset_outs", all_outs(), 32'd0);

    // arm together with a sample: no capture, no overrun.
    bus.arm          = 1'b1;
    bus.sample_valid = 1'b1;
    #1;
    chk("arm_sv_no_we", 32'(bus.cap_we), 32'd0);
    cyc();
    bus.arm          = 1'b0;
    bus.sample_valid = 1'b0;
    #1;
    chk("busy_after_arm", 32'(bus.busy), 32'd1);
    chk("arm_sv_no_overrun", 32'(bus.overrun), 32'd0);

    // Capture: bit-reversed addresses, with gaps in sample_valid.
    for (int t = 0; t < 10; t++) begin
      bus.sample_valid = cap_tab[t].sv;
      #1;
      chk("cap_we", 32'(bus.cap_we), 32'(cap_tab[t].exp_we));
      if (cap_tab[t].exp_we) chk("cap_addr", 32'(bus.cap_addr), 32'(cap_tab[t].exp_addr));
      cyc();
    end
    bus.sample_valid = 1'b0;
    #1;
    chk("compute_valid", 32'(bus.bfly_valid), 32'd1);
    chk("compute_busy", 32'(bus.busy), 32'd1);

    // Butterfly schedule with stalls, stage barrier and drain gaps.
    for (int e = 0; e < 12; e++) begin
      if (e == 4) begin
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          bus.bfly_ready = 1'b1;
          #1;
          if (bus.bfly_valid) bad++;
          cyc();
        end
        chk("barrier_hold", 32'(bad), 32'd0);
        bus.bfly_idle  = 1'b1;
        bus.bfly_ready = 1'b0;
        #1;
        chk("barrier_rise_cycle", 32'(bus.bfly_valid), 32'd0);
        cyc();
        chk("barrier_release", 32'(bus.bfly_valid), 32'd1);
      end
      if (e == 8) begin
        bus.bfly_ready = 1'b0;
        #1;
        chk("drain_gap", 32'(bus.bfly_valid), 32'd0);
        cyc();
      end
      for (int st = 0; st < bf_tab[e].stall; st++) begin
        bus.bfly_ready = 1'b0;
        #1;
        chk("bfly_stall_fields", bfly_fields(), 32'({1'b1, bf_tab[e].a, bf_tab[e].b, bf_tab[e].tw}));
        cyc();
      end
      bus.bfly_ready = 1'b1;
      if (e == 3) bus.bfly_idle = 1'b0;
      #1;
      chk("bfly_fields", bfly_fields(), 32'({1'b1, bf_tab[e].a, bf_tab[e].b, bf_tab[e].tw}));
      cyc();
    end
    bus.bfly_ready = 1'b0;
    #1;
    chk("last_drain_gap", 32'(bus.bfly_valid), 32'd0);
    chk("hs_total", 32'(hs_cnt), 32'd12);

    // Output: out_ready toggles 1,0,1,...
    n_rd      = 0;
    n_sync    = 0;
    exp_idx   = 0;
    prev_rd   = 1'b0;
    prev_addr = 3'd0;
    rdy       = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      cyc();
      bus.out_ready = rdy;
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'(prev_rd));
      chk("out_sync", 32'(bus.out_sync), 32'(prev_rd && (prev_addr == 3'd0)));
      chk("frame_done", 32'(bus.frame_done), 32'(prev_rd && (prev_addr == 3'd7)));
      if (bus.out_sync) n_sync++;
      if (bus.frame_done) begin
        done_seen = 1'b1;
        chk("idle_at_done", 32'(bus.busy), 32'd0);
      end
      if (!rdy) chk("rd_en_gated", 32'(bus.rd_en), 32'd0);
      if (bus.rd_en) begin
        chk("rd_addr", 32'(bus.rd_addr), 32'(exp_idx));
        exp_idx++;
        n_rd++;
      end
      prev_rd   = bus.rd_en;
      prev_addr = bus.rd_addr;
      rdy       = ~rdy;
    end
    bus.out_ready = 1'b0;
    chk("frame_done_seen", 32'(done_seen), 32'd1);
    chk("rd_count", 32'(n_rd), 32'd8);
    chk("sync_count", 32'(n_sync), 32'd1);

    // Second frame: overrun during COMPUTE.
    cyc();
    bus.arm = 1'b1;
    cyc();
    bus.arm = 1'b0;
    for (int t = 0; t < 8; t++) begin
      bus.sample_valid = 1'b1;
      cyc();
    end
    bus.sample_valid = 1'b1;
    #1;
    chk("overrun_no_we", 32'(bus.cap_we), 32'd0);
    chk("f2_compute_fields", bfly_fields(), 32'({1'b1, 3'd0, 3'd1, 2'd0}));
    cyc();
    bus.sample_valid = 1'b0;
    #1;
    chk("overrun_set", 32'(bus.overrun), 32'd1);
    cyc();
    cyc();
    chk("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Reset for 3 cycles in the middle of COMPUTE.
    bus.bfly_ready = 1'b1;
    cyc();
    rstn = 1'b0;
    cyc();
    chk("reset_mid_compute", all_outs(), 32'd0);
    cyc();
    cyc();
    rstn = 1'b1;
    bad  = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (bus.bfly_valid || bus.busy) bad++;
    end
    chk("post_abort_quiet", 32'(bad), 32'd0);
    bus.bfly_ready = 1'b0;

    // Overrun in IDLE, then arm clears it.
    bus.sample_valid = 1'b1;
    #1;
    chk("idle_sample_no_we", 32'(bus.cap_we), 32'd0);
    cyc();
    bus.sample_valid = 1'b0;
    #1;
    chk("idle_overrun_set", 32'(bus.overrun), 32'd1);
    bus.arm = 1'b1;
    cyc();
    bus.arm = 1'b0;
    #1;
    chk("arm_clears_overrun", 32'(bus.overrun), 32'd0);
    chk("arm_busy", 32'(bus.busy), 32'd1);

    rstn = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
